// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Optional MADD/MADDU accumulate ops are enabled by defining MD_MADD_EN.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        is_mul;
    logic        is_div;
    logic        is_madd;
    logic        launch;

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] prod;

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    logic [63:0] res;

    assign busy = (state == S_RUN);

    assign is_mul = start && (md_op == OP_MULT || md_op == OP_MULTU);
    assign is_div = start && (md_op == OP_DIV || md_op == OP_DIVU);
`ifdef MD_MADD_EN
    assign is_madd = start && (md_op == OP_MADD || md_op == OP_MADDU);
`else
    assign is_madd = 1'b0;
`endif
    assign launch = is_mul || is_div || is_madd;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    // op bit 0 marks the unsigned flavour for MULT/MULTU and MADD/MADDU.
    assign prod   = op_q[0] ? prod_u : prod_s;

    // Signed divide through magnitudes; 0x80000000/-1 falls out naturally.
    assign sgn    = ~op_q[0];
    assign a_neg  = sgn & a_q[31];
    assign b_neg  = sgn & b_q[31];
    assign a_mag  = a_neg ? -a_q : a_q;
    assign b_mag  = b_neg ? -b_q : b_q;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (b_q == 32'd0) ? 32'hFFFF_FFFF
                  : ((a_neg ^ b_neg) ? -q_mag : q_mag);
    assign rem    = (b_q == 32'd0) ? a_q
                  : (a_neg ? -r_mag : r_mag);

    // Select the {HI,LO} value written when the counter expires.
    always_comb begin
        res = {HI, LO};
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU:   res = {rem, quo};
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: res = {HI, LO} + prod;
`endif
            default:           res = {HI, LO};
        endcase
    end

    // Launch, count down, and retire operations into HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state <= S_RUN;
                        cnt   <= is_div ? DIV_N : MULT_N;
                        op_q  <= md_op;
                        a_q   <= A;
                        b_q   <= B;
                    end else if (start && md_op == OP_MTHI) begin
                        HI <= A;
                    end else if (start && md_op == OP_MTLO) begin
                        LO <= A;
                    end
                end
                default: begin
                    if (cnt <= 4'd1) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                        HI    <= res[63:32];
                        LO    <= res[31:0];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Expected values are hand-computed constants.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;
    int ncyc;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .A(A),
        .B(B),
        .busy(busy),
        .HI(HI),
        .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
        A = 32'd0;
        B = 32'd0;
    endtask

    // Count negedges with busy high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b1;

        issue(3'b000, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy_start", {31'd0, busy}, 32'd1);
        chk("mult_hold_lo", LO, 32'd0);
        wait_idle(ncyc);
        chk("mult_cycles", ncyc, 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        issue(3'b001, 32'hFFFF_FFFE, 32'd3);
        wait_idle(ncyc);
        chk("multu_cycles", ncyc, 32'd5);
        chk("multu_hi", HI, 32'h0000_0002);
        chk("multu_lo", LO, 32'hFFFF_FFFA);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_idle(ncyc);
        chk("div_cycles", ncyc, 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        issue(3'b011, 32'd7, 32'd2);
        wait_idle(ncyc);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);

        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(ncyc);
        chk("div_ovf_lo", LO, 32'h8000_0000);
        chk("div_ovf_hi", HI, 32'd0);

        issue(3'b011, 32'h0000_1234, 32'd0);
        wait_idle(ncyc);
        chk("divz_cycles", ncyc, 32'd10);
        chk("divz_lo", LO, 32'hFFFF_FFFF);
        chk("divz_hi", HI, 32'h0000_1234);

        issue(3'b010, 32'hFFFF_FFF6, 32'd0);
        wait_idle(ncyc);
        chk("divsz_lo", LO, 32'hFFFF_FFFF);
        chk("divsz_hi", HI, 32'hFFFF_FFF6);

        issue(3'b101, 32'hCAFE_BABE, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", LO, 32'hCAFE_BABE);
        chk("mtlo_hi", HI, 32'hFFFF_FFF6);

        issue(3'b100, 32'h1357_9BDF, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", HI, 32'h1357_9BDF);
        chk("mthi_lo", LO, 32'hCAFE_BABE);

        issue(3'b011, 32'd100, 32'd7);
        @(negedge clk);
        issue(3'b000, 32'd2, 32'd2);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        chk("ign_hi_hold", HI, 32'h1357_9BDF);
        chk("ign_lo_hold", LO, 32'hCAFE_BABE);
        wait_idle(ncyc);
        chk("ign_cycles", ncyc, 32'd7);
        chk("ign_lo", LO, 32'd14);
        chk("ign_hi", HI, 32'd2);
        repeat (8) @(negedge clk);
        chk("ign_no_mult_busy", {31'd0, busy}, 32'd0);
        chk("ign_no_mult_lo", LO, 32'd14);

        issue(3'b000, 32'd6, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_late_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_lo", LO, 32'd0);

        issue(3'b100, 32'd0, 32'd0);
        issue(3'b101, 32'hFFFF_FFFF, 32'd0);
        issue(3'b111, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        chk("maddu_busy", {31'd0, busy}, 32'd1);
        wait_idle(ncyc);
        chk("maddu_cycles", ncyc, 32'd5);
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
`else
        chk("maddu_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("maddu_late_busy", {31'd0, busy}, 32'd0);
        chk("maddu_hi", HI, 32'd0);
        chk("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

        issue(3'b000, 32'd3, 32'd4);
        wait_idle(ncyc);
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle(ncyc);
        chk("b2b_hi", HI, 32'd0);
        chk("b2b_lo", LO, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
